// File: rtl/keypad_scan.sv
`default_nettype none
// ------------------------------------------------------------------
// keypad_scan: 4x3 matrix keypad row scanner with whole-frame debounce
// Revision 1.0
// ------------------------------------------------------------------
module keypad_scan #(
  parameter int ROW_CYCLES      = 1,
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_col,
  output logic [3:0] key_row,
  output logic [9:0] keypad,
  output logic       key_star,
  output logic       key_sharp,
  output logic       key_pulse
);

  localparam logic [3:0] NONE      = 4'd15;
  localparam logic [3:0] CODE_STAR = 4'd10;
  localparam logic [3:0] CODE_SHRP = 4'd11;
  localparam logic [7:0] SLOT_LAST = 8'(ROW_CYCLES - 1);
  localparam logic [3:0] CNT_MAX   = 4'(DEBOUNCE_FRAMES);

  generate
    if (ROW_CYCLES < 1 || ROW_CYCLES > 255) begin : g_bad_row_cycles
      $error("keypad_scan: ROW_CYCLES out of range 1..255");
    end
    if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15) begin : g_bad_debounce
      $error("keypad_scan: DEBOUNCE_FRAMES out of range 1..15");
    end
  endgenerate

  logic [7:0]  slot_cnt;
  logic [1:0]  row_idx;
  logic [8:0]  acc;
  logic [3:0]  cand;
  logic [3:0]  cnt;
  logic [3:0]  stable;

  logic        sample;
  logic        frame_end;
  logic [11:0] frame_bits;
  logic [3:0]  pop;
  logic [3:0]  idx;
  logic [3:0]  result;
  logic [3:0]  cnt_next;
  logic [3:0]  stable_next;

  assign sample     = (slot_cnt == SLOT_LAST);
  assign frame_end  = sample && (row_idx == 2'd3);
  // Row 3 is never stored: its columns are merged straight into the result.
  assign frame_bits = {key_col, acc};

  always_comb begin
    pop    = 4'd0;
    idx    = 4'd0;
    result = NONE;
    for (int i = 0; i < 12; i++) begin
      if (frame_bits[i]) begin
        pop = pop + 4'd1;
        idx = 4'(i);
      end
    end
    if (pop == 4'd1) begin
      case (idx)
        4'd9:    result = CODE_STAR;
        4'd10:   result = 4'd0;
        4'd11:   result = CODE_SHRP;
        default: result = idx + 4'd1;
      endcase
    end
  end

  always_comb begin
    cnt_next = 4'd1;
    if (result == cand) begin
      cnt_next = (cnt == CNT_MAX) ? CNT_MAX : cnt + 4'd1;
    end
    stable_next = (cnt_next == CNT_MAX) ? result : stable;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= 8'd0;
      row_idx  <= 2'd0;
      key_row  <= 4'b0001;
      acc      <= 9'd0;
    end else if (sample) begin
      slot_cnt <= 8'd0;
      row_idx  <= row_idx + 2'd1;
      key_row  <= {key_row[2:0], key_row[3]};
      case (row_idx)
        2'd0:    acc[2:0] <= key_col;
        2'd1:    acc[5:3] <= key_col;
        2'd2:    acc[8:6] <= key_col;
        default: acc      <= 9'd0;
      endcase
    end else begin
      slot_cnt <= slot_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand      <= NONE;
      cnt       <= 4'd0;
      stable    <= NONE;
      keypad    <= 10'd0;
      key_star  <= 1'b0;
      key_sharp <= 1'b0;
      key_pulse <= 1'b0;
    end else begin
      key_pulse <= 1'b0;
      if (frame_end) begin
        cand      <= result;
        cnt       <= cnt_next;
        stable    <= stable_next;
        keypad    <= (stable_next <= 4'd9) ? (10'd1 << stable_next) : 10'd0;
        key_star  <= (stable_next == CODE_STAR);
        key_sharp <= (stable_next == CODE_SHRP);
        key_pulse <= (stable_next != stable) && (stable_next != NONE);
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/keypad_scan.md
# keypad_scan

Matrix-keypad front end for the watch datapath. It scans a 4-row × 3-column keypad, debounces the result over whole scan frames, and presents a clean one-hot `keypad[9:0]` level to the watch/time-set block, which does its own press-edge detection. `*` and `#` appear as separate level outputs, and every new stable press produces a single-cycle strobe.

## Interface
- `ROW_CYCLES`, default 1: clock cycles each row is driven, including the sample cycle; legal range 1..255.
- `DEBOUNCE_FRAMES`, default 5: consecutive identical frames required before the stable key changes; legal range 1..15.

- `clk`  input  1  system clock, 1 kHz.
- `rst`  input  1  reset; one clock; reset is asynchronous and active-high.
- `key_col`  input  3  column sense lines, active-high; bit c = column c.
- `key_row`  output  4  row drive, one-hot, active-high; bit r = row r.
- `keypad`  output  10  one-hot debounced digit level; bit d = digit d held; 0 = no digit.
- `key_star`  output  1  debounced `*` held.
- `key_sharp`  output  1  debounced `#` held.
- `key_pulse`  output  1  one-cycle strobe on a new stable press (digit, `*` or `#`).

## Operation
- **Key map (row, col) → code:**
  - Row 0: 1, 2, 3.
  - Row 1: 4, 5, 6.
  - Row 2: 7, 8, 9.
  - Row 3: `*`=10, 0, `#`=11.
  - NONE = 15.
- **Row scan:**
  - `slot_cnt` counts 0..ROW_CYCLES-1 per row. `row_idx` counts 0..3 and wraps to 0.
  - `key_row` = one-hot of `row_idx`, registered.
- **Sample edge:** the edge where `slot_cnt == ROW_CYCLES-1`.
  - `key_col` is sampled into the 12-bit frame accumulator at bits [3·row_idx +: 3].
  - On the same edge, `row_idx` advances.
  - `key_col` goes straight into the accumulator, with no synchronizer chain; it is the only consumer.
- **Frame end:** the sample edge of row 3.
  - The frame result uses the accumulator with row 3's columns merged in.
  - Exactly one bit set → that key's code. Zero bits → NONE. Two or more bits → NONE (multi-press is treated as a release).
  - The accumulator clears for the next frame.
- **Debounce, at frame end only:**
  - `n` = (result == cand) ? min(cnt+1, DEBOUNCE_FRAMES) : 1.
  - `cand` <= result; `cnt` <= n.
  - If n == DEBOUNCE_FRAMES, `stable` <= result.
  - `cnt` saturates, so a held key never re-triggers.
- **Outputs:** registered, updated on the frame-end edge from the next value of `stable`.
  - `keypad` = one-hot of stable if stable ≤ 9, else 0.
  - `key_star` = (stable == 10). `key_sharp` = (stable == 11).
  - `key_pulse` = 1 for exactly one cycle when next-stable ≠ stable and next-stable ≠ NONE. It is 0 on every other cycle.
  - Switching directly from one stable key to another (e.g. 3 → 4) with no NONE between them gives a new level and one pulse.
- **Reset values:**
  - `key_row` = 4'b0001, `slot_cnt` = 0, `row_idx` = 0, accumulator = 0.
  - `cand` = NONE, `cnt` = 0, `stable` = NONE.
  - `keypad` = 0, `key_star` = 0, `key_sharp` = 0, `key_pulse` = 0.
- **Reset mid-frame or mid-press:** all state clears immediately. A key still held after reset release needs DEBOUNCE_FRAMES full frames again.

## Timing
- Frame length = 4·ROW_CYCLES cycles. The k-th frame end is at rising edge 4·ROW_CYCLES·k after reset release (edges numbered from 1).
- Press latency, key steady before frame start: outputs change at frame end number DEBOUNCE_FRAMES. With defaults that is edge 20, i.e. 20 ms.
- Release latency: the same, DEBOUNCE_FRAMES frames of NONE.
- A key present in only part of a frame registers only if it is asserted at its row's sample edge.
- Bounce shorter than DEBOUNCE_FRAMES frames never changes the outputs.
- Between frame ends, all outputs hold. `key_pulse` is high only in the cycle after a frame-end edge.

## Test plan
- **Press 5:** reset, then hold `key_col[1]` high whenever `key_row[1]` = 1, defaults. Required: `keypad` = 10'b0000100000 from edge 20; `key_pulse` = 1 for that one cycle only; no change before edge 20.
- **Hold then release:** continue the 5 press for 40 frames, then release. Required: no second pulse while held; `keypad` = 0 exactly 5 frame ends after the first all-NONE frame; no pulse on release.
- **Bounce:** press 9 (row 2, col 2) for 3 frames, off for 1 frame, on for 3 frames, off. Required: `keypad` stays 0 and `key_pulse` is never asserted.
- **Multi-press and special keys:** press 1 and 2 together for 10 frames. Required: `keypad` = 0 and no pulse. Then press `*` alone. Required: `key_star` = 1 after 5 frames with one pulse, and `keypad` = 0. Repeat with `#` and check `key_sharp`.
- **Parameters and reset:** with ROW_CYCLES=3 and DEBOUNCE_FRAMES=1, press 0 (row 3, col 1). Required: `keypad` = 10'b0000000001 at edge 12. Then assert `rst` asynchronously mid-frame while the key is held. Required: all outputs 0 and `key_row` = 4'b0001 immediately; `keypad` reasserts 12 edges after reset release.
